// File: rtl/dac12_pkg.sv
// Shared widths, command codes and frame FSM states for the DAC12 SPI loader.
package dac12_pkg;

    localparam int unsigned DATA_W  = 12;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned FRAME_W = CMD_W + DATA_W;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'h0,
        CMD_WR     = 4'h1,
        CMD_ARM    = 4'h2,
        CMD_WR_ARM = 4'h3
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

endpackage

// File: rtl/dac12_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses on the synchronized level.
module dac12_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    assign sync = chain_q[STAGES-1];
    assign rise = rise_q;
    assign fall = fall_q;

    // Synchronizer chain; reset to the pin's idle level so no edge fires out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    // Registered edge pulses, one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= sync;
            rise_q <= sync & ~prev_q;
            fall_q <= ~sync & prev_q;
        end
    end

endmodule

// File: rtl/dac12_spi_loader.sv
// SPI mode-0 slave that loads a shadow DAC code and transfers it to the active code
// only on a PWM frame boundary.
module dac12_spi_loader #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned CMD_W       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              frame_start,
    output logic [DATA_W-1:0] dac_code,
    output logic              update_pending,
    output logic              frame_err
);

    import dac12_pkg::*;

    localparam int unsigned FW = CMD_W + DATA_W;
    localparam logic [4:0] CNT_SAT = 5'd17;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    dac12_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi_sclk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    dac12_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    dac12_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

    state_e            state_q, state_d;
    logic [FW-1:0]     sr_q, sr_d;
    logic [FW-1:0]     miso_sr_q, miso_sr_d;
    logic              miso_q, miso_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] dac_q, dac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic [FW-1:0]     readback;
    logic              commit, wr, arm, transfer;

    assign readback       = {{CMD_W{1'b0}}, dac_q};
    assign commit         = ena && (state_q == StCommit);
    assign spi_miso       = miso_q;
    assign dac_code       = dac_q;
    assign update_pending = pend_q;
    assign frame_err      = err_q;

    // Frame FSM next state; dropping ena aborts any frame in progress.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StShift;
            StShift:  if (cs_rise) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (!ena) state_d = StIdle;
    end

    // Shift register, saturating bit counter and MISO readback path.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        miso_sr_d = miso_sr_q;
        miso_d    = miso_q;
        if (ena && state_q == StIdle && cs_fall) begin
            cnt_d     = 5'd0;
            miso_sr_d = readback;
            miso_d    = readback[FW-1];
        end else if (ena && state_q == StShift) begin
            if (sclk_rise) begin
                sr_d = {sr_q[FW-2:0], mosi_sync};
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
            end
            if (sclk_fall) begin
                miso_sr_d = {miso_sr_q[FW-2:0], 1'b0};
                miso_d    = miso_sr_q[FW-2];
            end
        end
    end

    // Command decode at COMMIT plus the frame-boundary shadow-to-active transfer.
    always_comb begin
        shadow_d = shadow_q;
        dac_d    = dac_q;
        pend_d   = pend_q;
        err_d    = err_q;
        wr       = 1'b0;
        arm      = 1'b0;
        if (commit) begin
            if (cnt_q != 5'(FW)) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                case (cmd_e'(sr_q[FW-1 -: CMD_W]))
                    CMD_NOP:    ;
                    CMD_WR:     wr = 1'b1;
                    CMD_ARM:    arm = 1'b1;
                    CMD_WR_ARM: begin
                        wr  = 1'b1;
                        arm = 1'b1;
                    end
                    default:    err_d = 1'b1;
                endcase
            end
        end
        // An arm coinciding with frame_start waits for the next boundary.
        transfer = frame_start && pend_q && !arm;
        if (wr) shadow_d = sr_q[DATA_W-1:0];
        if (transfer) begin
            dac_d  = shadow_q;
            pend_d = 1'b0;
        end
        if (arm) pend_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sr_q      <= '0;
            miso_sr_q <= '0;
            miso_q    <= 1'b0;
            cnt_q     <= 5'd0;
            shadow_q  <= '0;
            dac_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            miso_sr_q <= miso_sr_d;
            miso_q    <= miso_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            dac_q     <= dac_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_dac12_spi_loader.sv
// Directed bench for dac12_spi_loader with a queue-based scoreboard.
module tb_dac12_spi_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        frame_start = 1'b0;
    logic [11:0] dac_code;
    logic        update_pending;
    logic        frame_err;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    dac12_spi_loader dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .frame_start(frame_start), .dac_code(dac_code),
        .update_pending(update_pending), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pop(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected <scoreboard empty>", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        exp_q.push_back(exp);
        check_pop(tag, obs);
    endtask

    task automatic fs_pulse();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    // Sends nbits LSBs of data MSB first; abort_after >= 0 drops ena after that many bits.
    // Returns on the negedge where cs_n is raised.
    task automatic spi_frame(input logic [16:0] data, input int nbits, input int abort_after,
                             input bit chk_miso);
        spi_cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_after) begin
                ena = 1'b0;
                cyc(2);
                spi_cs_n = 1'b1;
                cyc(5);
                ena = 1'b1;
                return;
            end
            spi_mosi = data[nbits-1-i];
            cyc(5);
            if (chk_miso) check_pop($sformatf("miso_bit%0d", i), {15'd0, spi_miso});
            spi_sclk = 1'b1;
            cyc(5);
            spi_sclk = 1'b0;
        end
        cyc(5);
        spi_cs_n = 1'b1;
    endtask

    initial begin
        logic [15:0] rb;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        expect_val("rst_dac", {4'd0, dac_code}, 16'h000);
        expect_val("rst_pend", {15'd0, update_pending}, 16'd0);
        expect_val("rst_err", {15'd0, frame_err}, 16'd0);
        expect_val("rst_miso", {15'd0, spi_miso}, 16'd0);

        // Write+arm, then commit timing and transfer.
        spi_frame(17'h03ABC, 16, -1, 1'b0);
        cyc(4);
        expect_val("pend_at_commit", {15'd0, update_pending}, 16'd0);
        cyc(1);
        expect_val("pend_after_commit", {15'd0, update_pending}, 16'd1);
        expect_val("dac_before_fs", {4'd0, dac_code}, 16'h000);
        expect_val("err_good", {15'd0, frame_err}, 16'd0);
        cyc(3);
        fs_pulse();
        expect_val("dac_xfer_abc", {4'd0, dac_code}, 16'hABC);
        expect_val("pend_clr", {15'd0, update_pending}, 16'd0);

        // Write without arm: frame boundaries must not move the code.
        spi_frame(17'h01123, 16, -1, 1'b0);
        cyc(8);
        expect_val("pend_wr_only", {15'd0, update_pending}, 16'd0);
        for (int k = 0; k < 5; k++) begin
            fs_pulse();
            cyc(2);
        end
        expect_val("dac_no_arm", {4'd0, dac_code}, 16'hABC);
        spi_frame(17'h02000, 16, -1, 1'b0);
        cyc(8);
        expect_val("pend_arm", {15'd0, update_pending}, 16'd1);
        fs_pulse();
        expect_val("dac_xfer_123", {4'd0, dac_code}, 16'h123);

        // Arm in the same cycle as frame_start.
        spi_frame(17'h03456, 16, -1, 1'b0);
        cyc(4);
        fs_pulse();
        expect_val("same_cyc_pend", {15'd0, update_pending}, 16'd1);
        expect_val("same_cyc_dac", {4'd0, dac_code}, 16'h123);
        cyc(3);
        fs_pulse();
        expect_val("next_fs_dac", {4'd0, dac_code}, 16'h456);
        expect_val("next_fs_pend", {15'd0, update_pending}, 16'd0);

        // Bad frame lengths and an illegal command.
        spi_frame(17'h03111, 15, -1, 1'b0);
        cyc(8);
        expect_val("err_15b", {15'd0, frame_err}, 16'd1);
        expect_val("pend_15b", {15'd0, update_pending}, 16'd0);
        spi_frame(17'h03FFF, 17, -1, 1'b0);
        cyc(8);
        expect_val("err_17b", {15'd0, frame_err}, 16'd1);
        expect_val("pend_17b", {15'd0, update_pending}, 16'd0);
        spi_frame(17'h00000, 16, -1, 1'b0);
        cyc(8);
        expect_val("err_clr_nop", {15'd0, frame_err}, 16'd0);
        spi_frame(17'h05FFF, 16, -1, 1'b0);
        cyc(8);
        expect_val("err_cmd5", {15'd0, frame_err}, 16'd1);
        expect_val("pend_cmd5", {15'd0, update_pending}, 16'd0);
        spi_frame(17'h02000, 16, -1, 1'b0);
        cyc(8);
        fs_pulse();
        expect_val("shadow_kept", {4'd0, dac_code}, 16'h456);

        // MISO readback of the active code.
        spi_frame(17'h035A5, 16, -1, 1'b0);
        cyc(8);
        fs_pulse();
        expect_val("dac_5a5", {4'd0, dac_code}, 16'h5A5);
        rb = 16'h05A5;
        for (int b = 15; b >= 0; b--) exp_q.push_back({15'd0, rb[b]});
        spi_frame(17'h00000, 16, -1, 1'b1);
        cyc(8);
        expect_val("err_after_rb", {15'd0, frame_err}, 16'd0);

        // ena dropped mid-frame: no error, shadow untouched.
        spi_frame(17'h03FFF, 16, 8, 1'b0);
        cyc(8);
        expect_val("abort_err", {15'd0, frame_err}, 16'd0);
        expect_val("abort_pend", {15'd0, update_pending}, 16'd0);
        spi_frame(17'h02000, 16, -1, 1'b0);
        cyc(8);
        fs_pulse();
        expect_val("abort_shadow", {4'd0, dac_code}, 16'h5A5);

        // Pending transfer still served with ena low.
        spi_frame(17'h03777, 16, -1, 1'b0);
        cyc(8);
        ena = 1'b0;
        cyc(2);
        fs_pulse();
        expect_val("xfer_ena_low", {4'd0, dac_code}, 16'h777);
        expect_val("pend_ena_low", {15'd0, update_pending}, 16'd0);
        ena = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
